// File: rtl/taus_sng_stream.sv
// Stochastic number generator: reseeds an external free-running RNG per job, then streams
// len Bernoulli bits with P(1) = prob / 2^PROB_W over a valid/ready handshake.
module taus_sng_stream #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PROB_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed_in,
    input  logic [PROB_W:0]   prob,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] rng_seed,
    output logic              rng_re_seed,
    input  logic [DATA_W-1:0] rng_rnd,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_out,
    output logic [LEN_W-1:0]  ones_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StReseed,
        StSettle,
        StStream,
        StDone
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_seed;
    logic [PROB_W:0]    r_prob;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_ones_count;
    logic               r_settle;
    logic               r_bit_out;
    logic               r_bit_valid;

    logic [PROB_W-1:0]  w_sample;
    logic               w_bit;
    logic               w_accept;
    logic               w_hs;
    logic               w_load;

    assign w_sample = rng_rnd[DATA_W-1 -: PROB_W];
    assign w_bit    = ({1'b0, w_sample} < r_prob);
    assign w_accept = (r_state == StIdle) && start;
    assign w_hs     = r_bit_valid && bit_ready;

    // r_remaining counts outstanding handshakes, so a new word may only be loaded while one
    // more than the bit currently being handed over is still owed.
    assign w_load = (r_state == StStream) &&
                    ((!r_bit_valid && (r_remaining != '0)) ||
                     (w_hs && (r_remaining > LEN_W'(1))));

    generate
        if (PROB_W < DATA_W) begin : g_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^rng_rnd[DATA_W-PROB_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = StReseed;
            StReseed: w_state_next = StSettle;
            StSettle: begin
                if (r_settle) begin
                    w_state_next = (r_remaining == '0) ? StDone : StStream;
                end
            end
            StStream: if (w_hs && (r_remaining == LEN_W'(1))) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed       <= '0;
            r_prob       <= '0;
            r_remaining  <= '0;
            r_ones_count <= '0;
            r_settle     <= 1'b0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
        end else begin
            r_settle <= (r_state == StSettle);
            if (w_accept) begin
                r_seed       <= seed_in;
                r_prob       <= prob;
                r_remaining  <= len;
                r_ones_count <= '0;
            end
            if (w_hs) begin
                r_remaining  <= r_remaining - LEN_W'(1);
                r_ones_count <= r_ones_count + LEN_W'(r_bit_out);
            end
            if (w_load) begin
                r_bit_out   <= w_bit;
                r_bit_valid <= 1'b1;
            end else if (w_hs) begin
                r_bit_out   <= 1'b0;
                r_bit_valid <= 1'b0;
            end
        end
    end

    assign rng_seed    = r_seed;
    assign rng_re_seed = (r_state == StReseed);
    assign bit_valid   = r_bit_valid;
    assign bit_out     = r_bit_out;
    assign ones_count  = r_ones_count;
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StDone);

endmodule
